// File: rtl/mips_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_bus_pkg
//  Description : Shared types and constants for the memory bus arbiter:
//                arbiter state encoding, error read-data pattern, port
//                numbering and the arbitration winner helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam logic [31:0] BUS_ERR_DATA    = 32'hDEAD_BEEF;
    localparam logic        BUS_PORT_IFETCH = 1'b0;
    localparam logic        BUS_PORT_DATA   = 1'b1;

    // Port that wins arbitration for the given request pair. On a tie the
    // round-robin policy hands the bus to whichever port did not own it last.
    function automatic logic pick_winner(input logic r0, input logic r1,
                                         input logic fixed_prio,
                                         input logic last_owner);
        logic w;
        if (r0 && r1) begin
            w = fixed_prio ? BUS_PORT_IFETCH : ~last_owner;
        end else if (r1) begin
            w = BUS_PORT_DATA;
        end else begin
            w = BUS_PORT_IFETCH;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/MUX_2_32.sv
`default_nettype none
// ============================================================================
//  Module      : MUX_2_32
//  Description : 32-bit 2:1 multiplexer.
//  Ports       : i_in0, i_in1 - data inputs; i_sel - select (1 picks i_in1);
//                o_out - selected data.
//  Revision    : 1.0 - initial release
// ============================================================================
module MUX_2_32 (
    input  logic [31:0] i_in0,
    input  logic [31:0] i_in1,
    input  logic        i_sel,
    output logic [31:0] o_out
);
    assign o_out = i_sel ? i_in1 : i_in0;
endmodule
`default_nettype wire

// File: rtl/bus_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bus_wait_timer
//  Description : Saturating wait-state counter with timeout compare.
//  Ports       : clk, rst (async, active high); i_clear - zero the count;
//                i_enable - count this cycle; o_expired - this counting cycle
//                is the TIMEOUT-th one (never asserted when TIMEOUT = 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int c_cnt_w = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = '1;
    localparam logic [c_cnt_w-1:0] c_last    = (TIMEOUT > 0) ? c_cnt_w'(TIMEOUT - 1) : '0;
    localparam logic               c_enabled = (TIMEOUT != 0);

    logic [c_cnt_w-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_enable && (cnt_q != c_cnt_max)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count reached so far plus the current waiting cycle hits TIMEOUT.
    assign o_expired = c_enabled & i_enable & (cnt_q >= c_last);

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Two-port arbiter (port 0 = instruction fetch, port 1 = data)
//                for the shared memory bus. Grants one requester, latches its
//                address/write data/write enable, runs one wait-stated memory
//                access with timeout and returns read data with a done pulse.
//  Ports       : clk, reset (async, active high)
//                req0/1, addr0/1, wdata0/1, we0/1 - requester side
//                done0/1, err0/1, rdata, sel   - completion and owner
//                mem_req, mem_addr, mem_wdata, mem_we, mem_ready, mem_rdata
//                                               - memory side
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic        we0,
    input  logic        we1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata,
    output logic        sel,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);
    arb_state_t  state_q, state_d;
    logic        sel_q, sel_d;
    logic        last_owner_q, last_owner_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done0_q, done0_d, done1_q, done1_d;
    logic        err0_q, err0_d, err1_q, err1_d;

    logic        w_grant;
    logic        w_sel_next;
    logic [31:0] w_mux_addr;
    logic [31:0] w_mux_wdata;
    logic        w_expired;
    logic        w_finish;

    assign w_grant    = (state_q == IDLE) && (req0 || req1);
    // Kept outside the main always_comb so the mux select does not depend on
    // the mux outputs through the same block.
    assign w_sel_next = w_grant ? pick_winner(req0, req1, FIXED_PRIO, last_owner_q) : sel_q;

    MUX_2_32 u_addr_mux (
        .i_in0 (addr0),
        .i_in1 (addr1),
        .i_sel (w_sel_next),
        .o_out (w_mux_addr)
    );

    MUX_2_32 u_wdata_mux (
        .i_in0 (wdata0),
        .i_in1 (wdata1),
        .i_sel (w_sel_next),
        .o_out (w_mux_wdata)
    );

    bus_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (reset),
        .i_clear   (state_q != BUSY),
        .i_enable  ((state_q == BUSY) && !mem_ready),
        .o_expired (w_expired)
    );

    assign w_finish = (state_q == BUSY) && (mem_ready || w_expired);

    always_comb begin
        state_d      = state_q;
        sel_d        = w_sel_next;
        last_owner_d = last_owner_q;
        mem_req_d    = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_d      = rdata_q;
        done0_d      = w_finish && !sel_q;
        done1_d      = w_finish &&  sel_q;
        err0_d       = w_finish && !mem_ready && !sel_q;
        err1_d       = w_finish && !mem_ready &&  sel_q;

        case (state_q)
            IDLE: begin
                if (w_grant) begin
                    state_d     = BUSY;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = w_mux_addr;
                    mem_wdata_d = w_mux_wdata;
                    mem_we_d    = w_sel_next ? we1 : we0;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_d = DONE;
                    rdata_d = mem_rdata;
                end else if (w_expired) begin
                    state_d = DONE;
                    rdata_d = BUS_ERR_DATA;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            DONE: begin
                // No arbitration here: the requester gets one edge to drop req.
                last_owner_d = sel_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sel_q        <= BUS_PORT_IFETCH;
            last_owner_q <= BUS_PORT_DATA;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata_q      <= '0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_owner_q <= last_owner_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
        end
    end

    assign done0     = done0_q;
    assign done1     = done1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign rdata     = rdata_q;
    assign sel       = sel_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    // The latched enable is only meaningful while the strobe is up.
    assign mem_we    = mem_we_q & mem_req_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_arbiter
//  Description : Self-checking bench for mem_bus_arbiter. Two instances
//                (round-robin and fixed priority, TIMEOUT = 4) share the
//                stimulus; the selected one is compared every cycle against
//                a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int TO = 4;
    localparam int PH_IDLE = 0;
    localparam int PH_BUSY = 1;
    localparam int PH_DONE = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        rr_done0, rr_done1, rr_err0, rr_err1, rr_sel, rr_mem_req, rr_mem_we;
    logic [31:0] rr_rdata, rr_mem_addr, rr_mem_wdata;
    logic        fp_done0, fp_done1, fp_err0, fp_err1, fp_sel, fp_mem_req, fp_mem_we;
    logic [31:0] fp_rdata, fp_mem_addr, fp_mem_wdata;

    logic        use_fp = 1'b0;
    logic        o_done0, o_done1, o_err0, o_err1, o_sel, o_mem_req, o_mem_we;
    logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.FIXED_PRIO(1'b0), .TIMEOUT(TO)) u_dut_rr (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1), .done0(rr_done0), .done1(rr_done1),
        .err0(rr_err0), .err1(rr_err1), .rdata(rr_rdata), .sel(rr_sel),
        .mem_req(rr_mem_req), .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata),
        .mem_we(rr_mem_we), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    mem_bus_arbiter #(.FIXED_PRIO(1'b1), .TIMEOUT(TO)) u_dut_fp (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1), .done0(fp_done0), .done1(fp_done1),
        .err0(fp_err0), .err1(fp_err1), .rdata(fp_rdata), .sel(fp_sel),
        .mem_req(fp_mem_req), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
        .mem_we(fp_mem_we), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    assign o_done0     = use_fp ? fp_done0     : rr_done0;
    assign o_done1     = use_fp ? fp_done1     : rr_done1;
    assign o_err0      = use_fp ? fp_err0      : rr_err0;
    assign o_err1      = use_fp ? fp_err1      : rr_err1;
    assign o_sel       = use_fp ? fp_sel       : rr_sel;
    assign o_mem_req   = use_fp ? fp_mem_req   : rr_mem_req;
    assign o_mem_we    = use_fp ? fp_mem_we    : rr_mem_we;
    assign o_rdata     = use_fp ? fp_rdata     : rr_rdata;
    assign o_mem_addr  = use_fp ? fp_mem_addr  : rr_mem_addr;
    assign o_mem_wdata = use_fp ? fp_mem_wdata : rr_mem_wdata;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: transaction phase, owner, latched request and result.
    int          m_ph;
    logic        m_sel, m_last, m_we, m_err;
    logic [31:0] m_addr, m_wdata, m_rdata;
    int          m_cnt, m_plan;
    int          next_wait = 0;
    logic        rand_mode = 1'b0;
    logic [31:0] dir_rdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = PH_IDLE; m_sel = 1'b0; m_last = 1'b1; m_we = 1'b0; m_err = 1'b0;
        m_addr = '0; m_wdata = '0; m_rdata = '0; m_cnt = 0; m_plan = 0;
    endtask

    task automatic check_outputs();
        chk("sel",       32'(o_sel),     32'(m_sel));
        chk("mem_req",   32'(o_mem_req), 32'(m_ph == PH_BUSY));
        chk("mem_we",    32'(o_mem_we),  32'(m_ph == PH_BUSY && m_we));
        chk("mem_addr",  o_mem_addr,     m_addr);
        chk("mem_wdata", o_mem_wdata,    m_wdata);
        chk("rdata",     o_rdata,        m_rdata);
        chk("done0",     32'(o_done0),   32'(m_ph == PH_DONE && !m_sel));
        chk("done1",     32'(o_done1),   32'(m_ph == PH_DONE && m_sel));
        chk("err0",      32'(o_err0),    32'(m_ph == PH_DONE && !m_sel && m_err));
        chk("err1",      32'(o_err1),    32'(m_ph == PH_DONE && m_sel && m_err));
    endtask

    // One clock: advance the model on the edge, compare, then drive inputs.
    task automatic step();
        logic win;
        @(posedge clk);
        if (m_ph == PH_IDLE) begin
            if (req0 || req1) begin
                if (req0 && req1) win = use_fp ? 1'b0 : ~m_last;
                else              win = req1;
                m_sel   = win;
                m_addr  = win ? addr1  : addr0;
                m_wdata = win ? wdata1 : wdata0;
                m_we    = win ? we1    : we0;
                m_cnt   = 0;
                m_plan  = rand_mode ? int'($urandom_range(0, 5)) : next_wait;
                m_ph    = PH_BUSY;
            end
        end else if (m_ph == PH_BUSY) begin
            if (mem_ready) begin
                m_rdata = mem_rdata; m_err = 1'b0; m_ph = PH_DONE;
            end else begin
                m_cnt++;
                if (m_cnt == TO) begin
                    m_rdata = 32'hDEAD_BEEF; m_err = 1'b1; m_ph = PH_DONE;
                end
            end
        end else begin
            m_last = m_sel;
            m_ph   = PH_IDLE;
        end
        #1;
        check_outputs();
        chk("done_excl", 32'(o_done0 & o_done1), 32'd0);

        if (m_ph == PH_BUSY) mem_ready = (m_cnt == m_plan);
        else                 mem_ready = rand_mode ? 1'($urandom) : 1'b0;
        mem_rdata = rand_mode ? $urandom : dir_rdata;

        if (rand_mode) begin
            if (m_ph == PH_DONE) begin
                if (m_sel) req1 = 1'($urandom);
                else       req0 = 1'($urandom);
            end else if (m_ph == PH_BUSY && $urandom_range(0, 7) == 0) begin
                if (m_sel) req1 = 1'b0;
                else       req0 = 1'b0;
            end
            if (!req0 && $urandom_range(0, 2) == 0) req0 = 1'b1;
            if (!req1 && $urandom_range(0, 2) == 0) req1 = 1'b1;
            addr0 = $urandom; addr1 = $urandom;
            wdata0 = $urandom; wdata1 = $urandom;
            we0 = 1'($urandom); we1 = 1'($urandom);
        end
    endtask

    task automatic run_until_done(input int bound, output int req_cycles);
        req_cycles = 0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (o_mem_req) req_cycles++;
            if (m_ph == PH_DONE) break;
        end
        vectors++;
        assert (m_ph == PH_DONE) else begin
            miscompares++;
            $error("FAIL txn_bound: observed phase %0d expected %0d", m_ph, PH_DONE);
        end
    endtask

    // Asynchronous reset pulse between clock edges, checked before any edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        #2 reset = 1'b0;
    endtask

    initial begin
        int rc;
        model_reset();
        #1 reset = 1'b1;
        #2;
        check_outputs();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single read on port 0, ready on the second BUSY cycle.
        addr0 = 32'h0040_0000; we0 = 1'b0; req0 = 1'b1;
        next_wait = 1; dir_rdata = 32'h2408_0005;
        run_until_done(10, rc);
        chk("read_done0", 32'(o_done0), 32'd1);
        chk("read_rdata", o_rdata, 32'h2408_0005);
        chk("read_sel", 32'(o_sel), 32'd0);
        chk("read_req_cycles", 32'(rc), 32'd2);
        req0 = 1'b0;
        step();

        // Round-robin contention, both held through four transactions.
        do_reset();
        req0 = 1'b1; req1 = 1'b1; addr1 = 32'h0000_1000; next_wait = 0;
        for (int t = 0; t < 4; t++) begin
            run_until_done(10, rc);
            chk("rr_order", 32'(o_sel), 32'(t % 2));
        end
        req0 = 1'b0; req1 = 1'b0;
        step(); step();

        // Write on port 1 with requester inputs disturbed during BUSY.
        addr1 = 32'h1000_0004; wdata1 = 32'hCAFE_F00D; we1 = 1'b1; req1 = 1'b1;
        next_wait = 3;
        step();
        addr1 = 32'h5555_0000; wdata1 = 32'h0BAD_0BAD; we1 = 1'b0; req1 = 1'b0;
        step();
        chk("wr_mem_we", 32'(o_mem_we), 32'd1);
        run_until_done(10, rc);
        chk("wr_done1", 32'(o_done1), 32'd1);
        chk("wr_addr_held", o_mem_addr, 32'h1000_0004);
        chk("wr_wdata_held", o_mem_wdata, 32'hCAFE_F00D);
        chk("wr_we_gated", 32'(o_mem_we), 32'd0);
        step();

        // Timeout on port 0, then a normal transaction.
        addr0 = 32'h0000_0100; we0 = 1'b0; req0 = 1'b1; next_wait = 99;
        run_until_done(10, rc);
        chk("to_err0", 32'(o_err0), 32'd1);
        chk("to_rdata", o_rdata, 32'hDEAD_BEEF);
        chk("to_busy_cycles", 32'(rc), 32'd4);
        req0 = 1'b0;
        step();
        req0 = 1'b1; next_wait = 0; dir_rdata = 32'h1234_5678;
        run_until_done(10, rc);
        chk("after_to_err0", 32'(o_err0), 32'd0);
        chk("after_to_rdata", o_rdata, 32'h1234_5678);
        req0 = 1'b0;
        step();

        // Reset in the middle of a transaction; first tie afterwards goes to 0.
        req1 = 1'b1; we1 = 1'b0; next_wait = 99;
        step();
        step();
        do_reset();
        req0 = 1'b1; req1 = 1'b1; next_wait = 0;
        step();
        chk("post_reset_tie", 32'(o_sel), 32'd0);
        run_until_done(10, rc);
        req0 = 1'b0; req1 = 1'b0;
        step();

        // Randomized traffic, round-robin instance.
        rand_mode = 1'b1;
        for (int i = 0; i < 400; i++) step();

        // Fixed priority: port 0 always wins while it keeps requesting.
        rand_mode = 1'b0; use_fp = 1'b1;
        req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b0;
        do_reset();
        req0 = 1'b1; req1 = 1'b1; next_wait = 0;
        for (int t = 0; t < 3; t++) begin
            run_until_done(10, rc);
            chk("fp_port0_wins", 32'(o_sel), 32'd0);
        end
        req0 = 1'b0;
        run_until_done(10, rc);
        chk("fp_port1_served", 32'(o_sel), 32'd1);
        req1 = 1'b0;
        step();

        // Randomized traffic, fixed-priority instance.
        rand_mode = 1'b1;
        for (int i = 0; i < 400; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter sharing the single system memory/bus port between instruction fetch (port 0) and data access (port 1). It selects a requester, latches that requester's address, write data and write-enable, and runs one memory transaction with a wait-state handshake and timeout. It returns read data with a one-cycle done pulse and drives the select line of the shared 32-bit 2:1 address/data muxes. It sits between the CPU core and the memory/peripheral bridge.

## Interface
- `FIXED_PRIO`, 0: 0 = round-robin on contention; 1 = port 0 always wins.
- `TIMEOUT`, 255: maximum BUSY cycles without `mem_ready` before abort; 0 disables the timeout.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0` / `req1`  in  1  transaction request; held high until the matching done pulse.
- `addr0` / `addr1`  in  32  byte address.
- `wdata0` / `wdata1`  in  32  write data.
- `we0` / `we1`  in  1  1 = write, 0 = read.
- `done0` / `done1`  out  1  one-cycle completion pulse.
- `err0` / `err1`  out  1  one-cycle timeout pulse, coincident with done.
- `rdata`  out  32  read data, valid while any done is high.
- `sel`  out  1  current owner: 0 = port 0, 1 = port 1.
- `mem_req`  out  1  memory access strobe.
- `mem_addr`  out  32  latched address.
- `mem_wdata`  out  32  latched write data.
- `mem_we`  out  1  latched write enable, gated by `mem_req`.
- `mem_ready`  in  1  memory completes the access in this cycle.
- `mem_rdata`  in  32  memory read data, valid when `mem_ready` is high.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requests: if `FIXED_PRIO`=1, grant port 0; otherwise grant the port that is not `last_owner`.
- Grant (IDLE→BUSY):
  - Register `sel` = winner.
  - Latch the winner's addr, wdata and we into `mem_addr`, `mem_wdata`, `mem_we`.
  - Clear the wait counter.
- BUSY:
  - `mem_req`=1 and the latched values are held constant.
  - Changes on requester inputs are ignored, including a dropped `req`; the transaction always completes.
  - `mem_ready`=1: capture `mem_rdata` into `rdata`; go to DONE.
  - Otherwise the wait counter increments. When the counter reaches `TIMEOUT` (with `TIMEOUT`≠0), set `rdata`=32'hDEAD_BEEF, set the error flag, and go to DONE.
- DONE:
  - `done<sel>`=1 for exactly one cycle; `err<sel>`=1 if the transaction was aborted.
  - `last_owner` ← `sel`; go to IDLE.
  - No arbitration happens in DONE. This gives the requester one edge to drop `req` after it sees done.
- Read and write transactions use the same flow. On writes, `rdata` carries `mem_rdata` unchanged and is don't-care to the requester.
- Wait counter width is clog2(`TIMEOUT`+1). It saturates and never wraps.
- `mem_ready` outside BUSY is ignored.
- `mem_we` = 0 whenever `mem_req` = 0.

## Timing
- Reset values: state IDLE, `sel`=0, `last_owner`=1 (port 0 wins the first tie), `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `rdata`=0, all done/err=0.
- Reset asserted mid-transaction: return to IDLE immediately (asynchronous). No done pulse is issued.
- Latency: `req` sampled at edge N → `mem_req` high from N+1. `mem_ready` sampled at edge M → done high for cycle M+1..M+2. The earliest next grant is at edge M+2.
- Zero-wait memory (`mem_ready` high in the first BUSY cycle): 3 cycles per transaction.
- Back-to-back contention under round-robin strictly alternates owners.

## Structure
- Shared package `mips_bus_pkg`:
  - State encoding `arb_state_t` (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
  - `BUS_ERR_DATA`=32'hDEAD_BEEF.
  - `BUS_PORT_IFETCH`=0, `BUS_PORT_DATA`=1.
- Latched address and wdata selection instantiates the existing `MUX_2_32` twice, with `sel` as the select.
- One natural sub-module, `bus_wait_timer`: the saturating counter plus timeout compare. Inputs: clear, enable. Output: expired.

## Test plan
- Single read, port 0:
  - Stimulus: addr0=32'h0040_0000, `mem_ready` on the 2nd BUSY cycle, `mem_rdata`=32'h2408_0005.
  - Required: `done0` pulse, `rdata`=32'h2408_0005, `sel`=0, `mem_req` high for exactly 2 cycles.
- Simultaneous requests, `FIXED_PRIO`=0, both held through 4 transactions:
  - Required grant order 0,1,0,1. `done0`/`done1` never high together.
- Same contention with `FIXED_PRIO`=1, port 1 re-requesting after every done:
  - Required: port 0 is served every time it requests; port 1 is served only when `req0`=0.
- Write, port 1, with addr1, wdata1 or `req1` changed during BUSY:
  - Stimulus: addr1=32'h1000_0004, wdata1=32'hCAFE_F00D, we1=1.
  - Required: `mem_addr`/`mem_wdata` stay at the latched values; `mem_we`=1 only while `mem_req`=1; `done1` is still issued.
- Timeout, `TIMEOUT`=4, `mem_ready` held 0:
  - Required: `done0` and `err0` pulse after 4 BUSY cycles; `rdata`=32'hDEAD_BEEF; the next request is served normally.
- Reset asserted during BUSY:
  - Required: all outputs at reset values asynchronously; no done/err pulse; the first tie after reset goes to port 0.
